branch_outcome_queue: RTL and testbench

//  In-order queue of in-flight branch predictions, between fetch (PHT output) and execute (branch resolution).

---
 rtl/branch_outcome_queue.sv | 146 ++++++++++++++
 tb/tb_branch_outcome_queue.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/branch_outcome_queue.sv
// rtl/branch_outcome_queue.sv - in-order queue of in-flight branch predictions with PHT training and redirect
// Optional BOQ_STATS_EN adds resolved/mispredicted branch counters.
module branch_outcome_queue #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 2
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              STALL,
   input  logic              Pred_Valid_IN,
   input  logic              Pred_Taken_IN,
   input  logic [31:0]       Pred_PC_IN,
   input  logic [31:0]       Pred_Target_IN,
   input  logic              Resolve_Valid_IN,
   input  logic              Resolve_Taken_IN,
   input  logic [31:0]       Resolve_Target_IN,
   output logic              Full_OUT,
   output logic [ADDR_W:0]   Count_OUT,
   output logic              Update_OUT,
   output logic              Resolution_OUT,
   output logic [31:0]       Update_PC_OUT,
   output logic              Mispredict_OUT,
   output logic [31:0]       Redirect_PC_OUT
`ifdef BOQ_STATS_EN
   ,
   output logic [31:0]       Stat_Resolved_OUT,
   output logic [31:0]       Stat_Mispred_OUT
`endif
);

   logic [31:0]       r_pc  [DEPTH];
   logic [31:0]       r_tgt [DEPTH];
   logic              r_tk  [DEPTH];
   logic [ADDR_W-1:0] r_rd_ptr;
   logic [ADDR_W-1:0] r_wr_ptr;
   logic [ADDR_W:0]   r_count;
   logic              r_update;
   logic              r_resolution;
   logic [31:0]       r_update_pc;
   logic              r_mispredict;
   logic [31:0]       r_redirect_pc;

   logic              w_full;
   logic              w_resolve;
   logic              w_mispredict;
   logic              w_push;
   logic [31:0]       w_head_pc;
   logic [31:0]       w_head_tgt;
   logic              w_head_tk;
   logic [ADDR_W:0]   w_count_nxt;

   assign w_head_pc  = r_pc[r_rd_ptr];
   assign w_head_tgt = r_tgt[r_rd_ptr];
   assign w_head_tk  = r_tk[r_rd_ptr];

   assign w_full       = (r_count == (ADDR_W+1)'(DEPTH));
   assign w_resolve    = Resolve_Valid_IN && (r_count != '0) && !STALL;
   assign w_mispredict = w_resolve &&
                         ((Resolve_Taken_IN != w_head_tk) ||
                          (Resolve_Taken_IN && w_head_tk && (Resolve_Target_IN != w_head_tgt)));
   // A full queue still accepts a branch when the head leaves the same cycle;
   // anything fetched alongside a mispredicting resolve is wrong-path.
   assign w_push       = Pred_Valid_IN && !STALL && !w_mispredict && (!w_full || w_resolve);

   always_comb begin
      w_count_nxt = r_count;
      if (w_mispredict) begin
         w_count_nxt = '0;
      end else if (w_push && !w_resolve) begin
         w_count_nxt = r_count + (ADDR_W+1)'(1);
      end else if (!w_push && w_resolve) begin
         w_count_nxt = r_count - (ADDR_W+1)'(1);
      end
   end

   always_ff @(posedge CLK) begin
      if (w_push) begin
         r_pc[r_wr_ptr]  <= Pred_PC_IN;
         r_tgt[r_wr_ptr] <= Pred_Target_IN;
         r_tk[r_wr_ptr]  <= Pred_Taken_IN;
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_rd_ptr      <= '0;
         r_wr_ptr      <= '0;
         r_count       <= '0;
         r_update      <= 1'b0;
         r_resolution  <= 1'b0;
         r_update_pc   <= '0;
         r_mispredict  <= 1'b0;
         r_redirect_pc <= '0;
      end else begin
         r_count      <= w_count_nxt;
         r_update     <= w_resolve;
         r_mispredict <= w_mispredict;
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
         end
         if (w_mispredict) begin
            r_rd_ptr <= r_wr_ptr;
         end else if (w_resolve) begin
            r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
         end
         if (w_resolve) begin
            r_resolution <= Resolve_Taken_IN;
            r_update_pc  <= w_head_pc;
         end
         if (w_mispredict) begin
            r_redirect_pc <= Resolve_Taken_IN ? Resolve_Target_IN : (w_head_pc + 32'd4);
         end
      end
   end

   assign Full_OUT        = w_full;
   assign Count_OUT       = r_count;
   assign Update_OUT      = r_update;
   assign Resolution_OUT  = r_resolution;
   assign Update_PC_OUT   = r_update_pc;
   assign Mispredict_OUT  = r_mispredict;
   assign Redirect_PC_OUT = r_redirect_pc;

`ifdef BOQ_STATS_EN
   logic [31:0] r_stat_resolved;
   logic [31:0] r_stat_mispred;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_stat_resolved <= '0;
         r_stat_mispred  <= '0;
      end else begin
         if (w_resolve) begin
            r_stat_resolved <= r_stat_resolved + 32'd1;
         end
         if (w_mispredict) begin
            r_stat_mispred <= r_stat_mispred + 32'd1;
         end
      end
   end

   assign Stat_Resolved_OUT = r_stat_resolved;
   assign Stat_Mispred_OUT  = r_stat_mispred;
`endif

endmodule

// File: tb/tb_branch_outcome_queue.sv
// tb/tb_branch_outcome_queue.sv - directed vector table plus randomized run against a queue-based model
module tb_branch_outcome_queue;
   localparam int DEPTH  = 4;
   localparam int ADDR_W = 2;

   logic              CLK;
   logic              RESET;
   logic              STALL;
   logic              Pred_Valid_IN;
   logic              Pred_Taken_IN;
   logic [31:0]       Pred_PC_IN;
   logic [31:0]       Pred_Target_IN;
   logic              Resolve_Valid_IN;
   logic              Resolve_Taken_IN;
   logic [31:0]       Resolve_Target_IN;
   logic              Full_OUT;
   logic [ADDR_W:0]   Count_OUT;
   logic              Update_OUT;
   logic              Resolution_OUT;
   logic [31:0]       Update_PC_OUT;
   logic              Mispredict_OUT;
   logic [31:0]       Redirect_PC_OUT;
`ifdef BOQ_STATS_EN
   logic [31:0]       Stat_Resolved_OUT;
   logic [31:0]       Stat_Mispred_OUT;
`endif

   branch_outcome_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .CLK               (CLK),
      .RESET             (RESET),
      .STALL             (STALL),
      .Pred_Valid_IN     (Pred_Valid_IN),
      .Pred_Taken_IN     (Pred_Taken_IN),
      .Pred_PC_IN        (Pred_PC_IN),
      .Pred_Target_IN    (Pred_Target_IN),
      .Resolve_Valid_IN  (Resolve_Valid_IN),
      .Resolve_Taken_IN  (Resolve_Taken_IN),
      .Resolve_Target_IN (Resolve_Target_IN),
      .Full_OUT          (Full_OUT),
      .Count_OUT         (Count_OUT),
      .Update_OUT        (Update_OUT),
      .Resolution_OUT    (Resolution_OUT),
      .Update_PC_OUT     (Update_PC_OUT),
      .Mispredict_OUT    (Mispredict_OUT),
      .Redirect_PC_OUT   (Redirect_PC_OUT)
`ifdef BOQ_STATS_EN
      ,
      .Stat_Resolved_OUT (Stat_Resolved_OUT),
      .Stat_Mispred_OUT  (Stat_Mispred_OUT)
`endif
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic        rst, stall, pv, pt;
      logic [31:0] ppc, ptg;
      logic        rv, rt;
      logic [31:0] rtg;
      logic [2:0]  cnt;
      logic        full, upd, res;
      logic [31:0] upc;
      logic        mis;
      logic [31:0] red;
   } vec_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] tgt;
      logic        tk;
   } ent_t;

   int          n_vec = 0;
   int          n_err = 0;
   vec_t        tbl[$];
   ent_t        mq[$];
   logic        m_upd, m_res, m_mis;
   logic [31:0] m_upc, m_red, m_sres, m_smis;

   function automatic vec_t mk(input logic rst, stall, pv, pt, input logic [31:0] ppc, ptg,
                               input logic rv, rt, input logic [31:0] rtg,
                               input logic [2:0] cnt, input logic full, upd, res,
                               input logic [31:0] upc, input logic mis, input logic [31:0] red);
      vec_t v;
      v.rst = rst; v.stall = stall; v.pv = pv; v.pt = pt; v.ppc = ppc; v.ptg = ptg;
      v.rv = rv; v.rt = rt; v.rtg = rtg; v.cnt = cnt; v.full = full; v.upd = upd;
      v.res = res; v.upc = upc; v.mis = mis; v.red = red;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   // Reference: the queue is a list of outstanding predictions; a resolve looks at the oldest.
   task automatic model_step(input logic rst, stall, pv, pt, input logic [31:0] ppc, ptg,
                             input logic rv, rt, input logic [31:0] rtg);
      ent_t h;
      ent_t e;
      bit   res_ok;
      bit   mis;
      m_upd = 1'b0;
      m_mis = 1'b0;
      if (rst) begin
         mq.delete();
         m_res = 1'b0; m_upc = '0; m_red = '0; m_sres = '0; m_smis = '0;
      end else if (!stall) begin
         res_ok = rv && (mq.size() > 0);
         mis    = 1'b0;
         if (res_ok) begin
            h      = mq.pop_front();
            mis    = (rt != h.tk) || (rt && h.tk && (rtg != h.tgt));
            m_upd  = 1'b1;
            m_res  = rt;
            m_upc  = h.pc;
            m_sres = m_sres + 1;
            if (mis) begin
               m_mis  = 1'b1;
               m_red  = rt ? rtg : h.pc + 32'd4;
               m_smis = m_smis + 1;
               mq.delete();
            end
         end
         if (pv && !mis && (mq.size() < DEPTH)) begin
            e.pc = ppc; e.tgt = ptg; e.tk = pt;
            mq.push_back(e);
         end
      end
   endtask

   task automatic drive_step(input logic rst, stall, pv, pt, input logic [31:0] ppc, ptg,
                             input logic rv, rt, input logic [31:0] rtg);
      RESET = rst; STALL = stall;
      Pred_Valid_IN = pv; Pred_Taken_IN = pt; Pred_PC_IN = ppc; Pred_Target_IN = ptg;
      Resolve_Valid_IN = rv; Resolve_Taken_IN = rt; Resolve_Target_IN = rtg;
      @(posedge CLK);
      #1;
      model_step(rst, stall, pv, pt, ppc, ptg, rv, rt, rtg);
      n_vec++;
   endtask

   initial begin
      ent_t h;
      logic pv, pt, rv, rt, rst, stall;
      logic [31:0] ppc, ptg, rtg;

      RESET = 1'b1; STALL = 1'b0; Pred_Valid_IN = 1'b0; Pred_Taken_IN = 1'b0;
      Pred_PC_IN = '0; Pred_Target_IN = '0; Resolve_Valid_IN = 1'b0;
      Resolve_Taken_IN = 1'b0; Resolve_Target_IN = '0;

      //         rst st pv pt ppc     ptg     rv rt rtg      cnt fu up re upc     mi red
      tbl.push_back(mk(1,0,0,0,0,      0,      0,0,0,       0,0,0,0,0,      0,0));
      tbl.push_back(mk(1,0,0,0,0,      0,      0,0,0,       0,0,0,0,0,      0,0));
      tbl.push_back(mk(0,0,1,1,'h100, 'h200,  0,0,0,       1,0,0,0,0,      0,0));
      tbl.push_back(mk(0,0,0,0,0,      0,      1,1,'h200,   0,0,1,1,'h100,  0,0));
      tbl.push_back(mk(0,0,0,0,0,      0,      0,0,0,       0,0,0,1,'h100,  0,0));
      tbl.push_back(mk(0,0,1,0,'h10,  0,      0,0,0,       1,0,0,1,'h100,  0,0));
      tbl.push_back(mk(0,0,1,0,'h14,  0,      0,0,0,       2,0,0,1,'h100,  0,0));
      tbl.push_back(mk(0,0,1,0,'h18,  0,      0,0,0,       3,0,0,1,'h100,  0,0));
      tbl.push_back(mk(0,0,1,0,'h1c,  0,      0,0,0,       4,1,0,1,'h100,  0,0));
      tbl.push_back(mk(0,0,1,0,'h20,  0,      0,0,0,       4,1,0,1,'h100,  0,0));
      tbl.push_back(mk(0,0,1,0,'h24,  0,      1,0,0,       4,1,1,0,'h10,   0,0));
      tbl.push_back(mk(0,0,1,0,'h28,  0,      1,0,0,       4,1,1,0,'h14,   0,0));
      tbl.push_back(mk(0,0,0,0,0,      0,      1,0,0,       3,0,1,0,'h18,   0,0));
      tbl.push_back(mk(0,0,0,0,0,      0,      1,0,0,       2,0,1,0,'h1c,   0,0));
      tbl.push_back(mk(0,0,0,0,0,      0,      1,0,0,       1,0,1,0,'h24,   0,0));
      tbl.push_back(mk(0,0,0,0,0,      0,      1,0,0,       0,0,1,0,'h28,   0,0));
      tbl.push_back(mk(0,0,0,0,0,      0,      1,0,0,       0,0,0,0,'h28,   0,0));
      tbl.push_back(mk(0,0,1,0,'h100, 0,      0,0,0,       1,0,0,0,'h28,   0,0));
      tbl.push_back(mk(0,0,1,0,'h104, 0,      0,0,0,       2,0,0,0,'h28,   0,0));
      tbl.push_back(mk(0,0,1,0,'h108, 0,      0,0,0,       3,0,0,0,'h28,   0,0));
      tbl.push_back(mk(0,0,1,0,'h10c, 0,      1,1,'h300,   0,0,1,1,'h100,  1,'h300));
      tbl.push_back(mk(0,0,0,0,0,      0,      0,0,0,       0,0,0,1,'h100,  0,'h300));
      tbl.push_back(mk(0,0,1,1,'h400, 'h500,  0,0,0,       1,0,0,1,'h100,  0,'h300));
      tbl.push_back(mk(0,1,0,0,0,      0,      1,0,0,       1,0,0,1,'h100,  0,'h300));
      tbl.push_back(mk(0,0,0,0,0,      0,      1,0,0,       0,0,1,0,'h400,  1,'h404));
      tbl.push_back(mk(0,0,1,1,'h600, 'h700,  0,0,0,       1,0,0,0,'h400,  0,'h404));
      tbl.push_back(mk(0,0,1,1,'h800, 'h900,  1,1,'h704,   0,0,1,1,'h600,  1,'h704));
      tbl.push_back(mk(0,1,1,1,'h900, 'h904,  0,0,0,       0,0,0,1,'h600,  0,'h704));
      tbl.push_back(mk(0,0,1,1,'ha00, 'ha04,  0,0,0,       1,0,0,1,'h600,  0,'h704));
      tbl.push_back(mk(1,0,0,0,0,      0,      1,1,'ha04,   0,0,0,0,0,      0,0));
      tbl.push_back(mk(0,0,0,0,0,      0,      1,1,'ha04,   0,0,0,0,0,      0,0));

      for (int i = 0; i < tbl.size(); i++) begin
         drive_step(tbl[i].rst, tbl[i].stall, tbl[i].pv, tbl[i].pt, tbl[i].ppc, tbl[i].ptg,
                    tbl[i].rv, tbl[i].rt, tbl[i].rtg);
         chk($sformatf("row%0d count", i),       32'(Count_OUT),       32'(tbl[i].cnt));
         chk($sformatf("row%0d full", i),        32'(Full_OUT),        32'(tbl[i].full));
         chk($sformatf("row%0d update", i),      32'(Update_OUT),      32'(tbl[i].upd));
         chk($sformatf("row%0d resolution", i),  32'(Resolution_OUT),  32'(tbl[i].res));
         chk($sformatf("row%0d update_pc", i),   Update_PC_OUT,        tbl[i].upc);
         chk($sformatf("row%0d mispredict", i),  32'(Mispredict_OUT),  32'(tbl[i].mis));
         chk($sformatf("row%0d redirect_pc", i), Redirect_PC_OUT,      tbl[i].red);
`ifdef BOQ_STATS_EN
         chk($sformatf("row%0d stat_resolved", i), Stat_Resolved_OUT, m_sres);
         chk($sformatf("row%0d stat_mispred", i),  Stat_Mispred_OUT,  m_smis);
`endif
      end

      for (int n = 0; n < 3000; n++) begin
         rst   = ($urandom_range(199) == 0);
         stall = ($urandom_range(7) == 0);
         pv    = ($urandom_range(1) == 0);
         pt    = $urandom_range(1);
         ppc   = $urandom & 32'hffff_fffc;
         ptg   = $urandom & 32'hffff_fffc;
         rv    = ($urandom_range(2) == 0);
         rt    = $urandom_range(1);
         rtg   = $urandom & 32'hffff_fffc;
         if (mq.size() > 0 && $urandom_range(3) != 0) begin
            h   = mq[0];
            rt  = h.tk;
            if ($urandom_range(3) != 0) rtg = h.tgt;
         end
         drive_step(rst, stall, pv, pt, ppc, ptg, rv, rt, rtg);
         chk($sformatf("rnd%0d count", n),       32'(Count_OUT),      mq.size());
         chk($sformatf("rnd%0d full", n),        32'(Full_OUT),       32'(mq.size() == DEPTH));
         chk($sformatf("rnd%0d update", n),      32'(Update_OUT),     32'(m_upd));
         chk($sformatf("rnd%0d resolution", n),  32'(Resolution_OUT), 32'(m_res));
         chk($sformatf("rnd%0d update_pc", n),   Update_PC_OUT,       m_upc);
         chk($sformatf("rnd%0d mispredict", n),  32'(Mispredict_OUT), 32'(m_mis));
         chk($sformatf("rnd%0d redirect_pc", n), Redirect_PC_OUT,     m_red);
`ifdef BOQ_STATS_EN
         chk($sformatf("rnd%0d stat_resolved", n), Stat_Resolved_OUT, m_sres);
         chk($sformatf("rnd%0d stat_mispred", n),  Stat_Mispred_OUT,  m_smis);
`endif
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
